// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared constants and types for the two-port ALU arbiter.
//   - OP_* function indices (0..17), OP_COUNT
//   - CTRL_TABLE: op index -> {zx,nx,zy,ny,f,no}
//   - CTRL_ILLEGAL: control word used for out-of-range ops (constant 0)
//   - decode_op / op_illegal helpers
package alu_arbiter_pkg;

    localparam int OP_COUNT = 18;

    localparam logic [4:0] OP_ZERO  = 5'd0;
    localparam logic [4:0] OP_ONE   = 5'd1;
    localparam logic [4:0] OP_NEG1  = 5'd2;
    localparam logic [4:0] OP_X     = 5'd3;
    localparam logic [4:0] OP_Y     = 5'd4;
    localparam logic [4:0] OP_NOTX  = 5'd5;
    localparam logic [4:0] OP_NOTY  = 5'd6;
    localparam logic [4:0] OP_NEGX  = 5'd7;
    localparam logic [4:0] OP_NEGY  = 5'd8;
    localparam logic [4:0] OP_XP1   = 5'd9;
    localparam logic [4:0] OP_YP1   = 5'd10;
    localparam logic [4:0] OP_XM1   = 5'd11;
    localparam logic [4:0] OP_YM1   = 5'd12;
    localparam logic [4:0] OP_ADD   = 5'd13;
    localparam logic [4:0] OP_XSUBY = 5'd14;
    localparam logic [4:0] OP_YSUBX = 5'd15;
    localparam logic [4:0] OP_AND   = 5'd16;
    localparam logic [4:0] OP_OR    = 5'd17;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } ctrl_t;

    localparam logic [5:0] CTRL_ILLEGAL = 6'b101010;

    // Entry k is the control word for op k (leftmost entry is op 17).
    localparam logic [OP_COUNT-1:0][5:0] CTRL_TABLE = {
        6'b010101,  // 17 x|y
        6'b000000,  // 16 x&y
        6'b000111,  // 15 y-x
        6'b010011,  // 14 x-y
        6'b000010,  // 13 x+y
        6'b110010,  // 12 y-1
        6'b001110,  // 11 x-1
        6'b110111,  // 10 y+1
        6'b011111,  //  9 x+1
        6'b110011,  //  8 -y
        6'b001111,  //  7 -x
        6'b110001,  //  6 !y
        6'b001101,  //  5 !x
        6'b110000,  //  4 y
        6'b001100,  //  3 x
        6'b111010,  //  2 -1
        6'b111111,  //  1 1
        6'b101010   //  0 0
    };

    function automatic logic op_illegal(input logic [4:0] op);
        return op >= 5'(OP_COUNT);
    endfunction

    function automatic ctrl_t decode_op(input logic [4:0] op);
        if (op_illegal(op))
            return ctrl_t'(CTRL_ILLEGAL);
        return ctrl_t'(CTRL_TABLE[op]);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshake bundle for both requesters.
//   reqN_valid/ready/op/x/y   : requester N -> arbiter operation
//   respN_valid/ready/out/zr/ng/err : arbiter -> requester N result
//   modport slave  : arbiter side
//   modport master : requester side
interface alu_arbiter_if #(parameter int W = 8);

    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [4:0]   req0_op, req1_op;
    logic [W-1:0] req0_x, req0_y, req1_x, req1_y;

    logic         resp0_valid, resp1_valid;
    logic         resp0_ready, resp1_ready;
    logic [W-1:0] resp0_out, resp1_out;
    logic         resp0_zr, resp0_ng, resp0_err;
    logic         resp1_zr, resp1_ng, resp1_err;

    modport slave (
        input  req0_valid, req0_op, req0_x, req0_y,
        input  req1_valid, req1_op, req1_x, req1_y,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_out, resp0_zr, resp0_ng, resp0_err,
        output resp1_valid, resp1_out, resp1_zr, resp1_ng, resp1_err,
        input  resp0_ready, resp1_ready
    );

    modport master (
        output req0_valid, req0_op, req0_x, req0_y,
        output req1_valid, req1_op, req1_x, req1_y,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_out, resp0_zr, resp0_ng, resp0_err,
        input  resp1_valid, resp1_out, resp1_zr, resp1_ng, resp1_err,
        output resp0_ready, resp1_ready
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// alu: combinational control-word ALU (zx,nx,zy,ny,f,no).
//   x, y        : operands
//   zx..no      : zero/negate x, zero/negate y, add(1)/and(0), negate out
//   out, zr, ng : result, result==0, result MSB
module alu #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         zx,
    input  logic         nx,
    input  logic         zy,
    input  logic         ny,
    input  logic         f,
    input  logic         no,
    output logic [W-1:0] out,
    output logic         zr,
    output logic         ng
);

    logic [W-1:0] xa, ya, r;

    always_comb begin
        xa  = zx ? '0 : x;
        xa  = nx ? ~xa : xa;
        ya  = zy ? '0 : y;
        ya  = ny ? ~ya : ya;
        r   = f ? (xa + ya) : (xa & ya);
        out = no ? ~r : r;
        zr  = (out == '0);
        ng  = out[W-1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters.
//   clk, reset : clock, async active-high reset
//   bus        : alu_arbiter_if slave (req/resp handshakes for ports 0 and 1)
// Pipeline: grant (decode+register into stage 1) -> compute (alu from stage 1,
// capture into the port's response register) -> response held until consumed.
// Each port is busy from its grant until its response is consumed, so at most
// one operation per port is ever in flight.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);

    logic [1:0]        req_valid, resp_ready;
    logic [1:0][4:0]   req_op;
    logic [1:0][W-1:0] req_x, req_y;

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign resp_ready = {bus.resp1_ready, bus.resp0_ready};
    assign req_op     = {bus.req1_op, bus.req0_op};
    assign req_x      = {bus.req1_x, bus.req0_x};
    assign req_y      = {bus.req1_y, bus.req0_y};

    logic [1:0] busy_q, busy_d;
    logic       ptr_q, ptr_d;

    logic         s1_v_q, s1_v_d;
    logic         s1_id_q, s1_id_d;
    ctrl_t        s1_ctrl_q, s1_ctrl_d;
    logic         s1_err_q, s1_err_d;
    logic [W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;

    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [1:0][W-1:0] resp_out_q, resp_out_d;
    logic [1:0]        resp_zr_q, resp_zr_d;
    logic [1:0]        resp_ng_q, resp_ng_d;
    logic [1:0]        resp_err_q, resp_err_d;

    logic [1:0]   elig, ready, grant, consume;
    logic         gsel;
    logic [W-1:0] alu_out;
    logic         alu_zr, alu_ng;

    // Arbitration. A port's ready looks only at the other port's valid, so
    // ready never combinationally depends on its own valid.
    always_comb begin
        elig     = ~busy_q;
        ready[0] = !reset && elig[0] && (!(elig[1] && req_valid[1]) || !ptr_q);
        ready[1] = !reset && elig[1] && (!(elig[0] && req_valid[0]) ||  ptr_q);
        grant    = req_valid & ready;
        gsel     = grant[1];
        consume  = resp_valid_q & resp_ready;
        ptr_d    = ptr_q;
        if (|grant)
            ptr_d = ~gsel;
        busy_d   = (busy_q | grant) & ~consume;
    end

    // Stage 1: decoded controls, operands and owner of the granted request.
    always_comb begin
        s1_v_d    = |grant;
        s1_id_d   = s1_id_q;
        s1_ctrl_d = s1_ctrl_q;
        s1_err_d  = s1_err_q;
        s1_x_d    = s1_x_q;
        s1_y_d    = s1_y_q;
        if (|grant) begin
            s1_id_d   = gsel;
            s1_ctrl_d = decode_op(req_op[gsel]);
            s1_err_d  = op_illegal(req_op[gsel]);
            s1_x_d    = req_x[gsel];
            s1_y_d    = req_y[gsel];
        end
    end

    alu #(.W(W)) u_alu (
        .x  (s1_x_q),
        .y  (s1_y_q),
        .zx (s1_ctrl_q.zx),
        .nx (s1_ctrl_q.nx),
        .zy (s1_ctrl_q.zy),
        .ny (s1_ctrl_q.ny),
        .f  (s1_ctrl_q.f),
        .no (s1_ctrl_q.no),
        .out(alu_out),
        .zr (alu_zr),
        .ng (alu_ng)
    );

    // Response registers: capture from stage 1, hold until consumed.
    always_comb begin
        resp_valid_d = resp_valid_q & ~resp_ready;
        resp_out_d   = resp_out_q;
        resp_zr_d    = resp_zr_q;
        resp_ng_d    = resp_ng_q;
        resp_err_d   = resp_err_q;
        for (int n = 0; n < 2; n++) begin
            if (s1_v_q && s1_id_q == 1'(n)) begin
                resp_valid_d[n] = 1'b1;
                resp_out_d[n]   = alu_out;
                resp_zr_d[n]    = alu_zr;
                resp_ng_d[n]    = alu_ng;
                resp_err_d[n]   = s1_err_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q       <= '0;
            ptr_q        <= 1'b0;
            s1_v_q       <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_ctrl_q    <= '0;
            s1_err_q     <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            resp_valid_q <= '0;
            resp_out_q   <= '0;
            resp_zr_q    <= '0;
            resp_ng_q    <= '0;
            resp_err_q   <= '0;
        end else begin
            busy_q       <= busy_d;
            ptr_q        <= ptr_d;
            s1_v_q       <= s1_v_d;
            s1_id_q      <= s1_id_d;
            s1_ctrl_q    <= s1_ctrl_d;
            s1_err_q     <= s1_err_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            resp_valid_q <= resp_valid_d;
            resp_out_q   <= resp_out_d;
            resp_zr_q    <= resp_zr_d;
            resp_ng_q    <= resp_ng_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req0_ready  = ready[0];
    assign bus.req1_ready  = ready[1];
    assign bus.resp0_valid = resp_valid_q[0];
    assign bus.resp1_valid = resp_valid_q[1];
    assign bus.resp0_out   = resp_out_q[0];
    assign bus.resp1_out   = resp_out_q[1];
    assign bus.resp0_zr    = resp_zr_q[0];
    assign bus.resp1_zr    = resp_zr_q[1];
    assign bus.resp0_ng    = resp_ng_q[0];
    assign bus.resp1_ng    = resp_ng_q[1];
    assign bus.resp0_err   = resp_err_q[0];
    assign bus.resp1_err   = resp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a per-port expected-
// result queue filled at request transfer and drained at response.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.W(8)) bus();

    alu_arbiter #(.W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] out;
        logic       zr;
        logic       ng;
        logic       err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: direct arithmetic per function index.
    function automatic exp_t model(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        logic [7:0] r;
        e.err = 1'b0;
        case (op)
            5'd0:  r = 8'h00;
            5'd1:  r = 8'h01;
            5'd2:  r = 8'hFF;
            5'd3:  r = x;
            5'd4:  r = y;
            5'd5:  r = ~x;
            5'd6:  r = ~y;
            5'd7:  r = 8'h00 - x;
            5'd8:  r = 8'h00 - y;
            5'd9:  r = x + 8'd1;
            5'd10: r = y + 8'd1;
            5'd11: r = x - 8'd1;
            5'd12: r = y - 8'd1;
            5'd13: r = x + y;
            5'd14: r = x - y;
            5'd15: r = y - x;
            5'd16: r = x & y;
            5'd17: r = x | y;
            default: begin r = 8'h00; e.err = 1'b1; end
        endcase
        e.out = r;
        e.zr  = (r == 8'h00);
        e.ng  = r[7];
        return e;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [4:0] op,
                           input logic [7:0] x, input logic [7:0] y);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_x = x; bus.req0_y = y;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_x = x; bus.req1_y = y;
        end
    endtask

    task automatic set_rr(input int p, input logic v);
        if (p == 0) bus.resp0_ready = v;
        else        bus.resp1_ready = v;
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic rvld(input int p);
        return (p == 0) ? bus.resp0_valid : bus.resp1_valid;
    endfunction

    function automatic exp_t obs(input int p);
        exp_t o;
        if (p == 0) begin
            o.out = bus.resp0_out; o.zr = bus.resp0_zr; o.ng = bus.resp0_ng; o.err = bus.resp0_err;
        end else begin
            o.out = bus.resp1_out; o.zr = bus.resp1_zr; o.ng = bus.resp1_ng; o.err = bus.resp1_err;
        end
        return o;
    endfunction

    task automatic push(input int p, input exp_t e);
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic cmp(input string tag, input exp_t o, input exp_t e);
        chk({tag, ".out"}, 32'(o.out), 32'(e.out));
        chk({tag, ".zr"},  32'(o.zr),  32'(e.zr));
        chk({tag, ".ng"},  32'(o.ng),  32'(e.ng));
        chk({tag, ".err"}, 32'(o.err), 32'(e.err));
    endtask

    // Called at posedge+2; returns at posedge+2 just after the transfer edge.
    task automatic issue(input int p, input logic [4:0] op, input logic [7:0] x,
                         input logic [7:0] y, input string tag);
        int n;
        n = 0;
        set_req(p, 1'b1, op, x, y);
        #1;
        while (!rdy(p) && n < 20) begin
            @(posedge clk); #3;
            n++;
        end
        chk({tag, ".accept"}, 32'(rdy(p)), 32'd1);
        push(p, model(op, x, y));
        @(posedge clk); #2;
        set_req(p, 1'b0, op, x, y);
    endtask

    // Waits for the response, checks latency (edges < 0 skips it), pops and
    // compares, then consumes it and checks that valid drops.
    task automatic await_resp(input int p, input int edges, input string tag);
        int n;
        int sz;
        exp_t e;
        n = 0;
        #1;
        while (!rvld(p) && n < 20) begin
            @(posedge clk); #3;
            n++;
        end
        chk({tag, ".valid"}, 32'(rvld(p)), 32'd1);
        if (edges >= 0)
            chk({tag, ".latency"}, 32'(n), 32'(edges));
        sz = (p == 0) ? q0.size() : q1.size();
        chk({tag, ".queued"}, 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            cmp(tag, obs(p), e);
        end
        set_rr(p, 1'b1);
        @(posedge clk); #2;
        set_rr(p, 1'b0);
        #1;
        chk({tag, ".drop"}, 32'(rvld(p)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e0;
        exp_t e;
        reset = 1'b1;
        set_req(0, 1'b0, 5'd0, 8'h00, 8'h00);
        set_req(1, 1'b0, 5'd0, 8'h00, 8'h00);
        set_rr(0, 1'b0);
        set_rr(1, 1'b0);
        #3;
        chk("rst.rdy0", 32'(rdy(0)), 32'd0);
        chk("rst.rdy1", 32'(rdy(1)), 32'd0);
        chk("rst.rv0", 32'(rvld(0)), 32'd0);
        chk("rst.rv1", 32'(rvld(1)), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("idle.rdy0", 32'(rdy(0)), 32'd1);
        chk("idle.rdy1", 32'(rdy(1)), 32'd1);
        @(posedge clk); #2;

        // Both ports valid together: pointer at 0 grants port 0, then port 1.
        set_req(0, 1'b1, 5'd14, 8'd17, 8'd6);
        set_req(1, 1'b1, 5'd15, 8'd17, 8'd6);
        #1;
        chk("both.rdy0", 32'(rdy(0)), 32'd1);
        chk("both.rdy1", 32'(rdy(1)), 32'd0);
        push(0, model(5'd14, 8'd17, 8'd6));
        @(posedge clk); #2;
        set_req(0, 1'b0, 5'd14, 8'd17, 8'd6);
        #1;
        chk("both.rdy1b", 32'(rdy(1)), 32'd1);
        push(1, model(5'd15, 8'd17, 8'd6));
        @(posedge clk); #2;
        set_req(1, 1'b0, 5'd15, 8'd17, 8'd6);
        await_resp(0, 0, "xsuby");
        await_resp(1, 0, "ysubx");

        // Single-port ops with 2-cycle latency.
        @(posedge clk); #2;
        issue(0, 5'd13, 8'd17, 8'd6, "add");
        await_resp(0, 1, "add");
        @(posedge clk); #2;
        issue(0, 5'd16, 8'd17, 8'd6, "and");
        await_resp(0, 1, "and");
        @(posedge clk); #2;
        issue(0, 5'd17, 8'd17, 8'd6, "or");
        await_resp(0, 1, "or");
        @(posedge clk); #2;
        issue(1, 5'd20, 8'd17, 8'd6, "ill20");
        await_resp(1, 1, "ill20");
        @(posedge clk); #2;
        issue(0, 5'd18, 8'hAA, 8'h55, "ill18");
        await_resp(0, 1, "ill18");
        @(posedge clk); #2;
        issue(1, 5'd31, 8'hAA, 8'h55, "ill31");
        await_resp(1, 1, "ill31");

        // Remaining functions with random operands, alternating ports.
        for (int op = 0; op < 13; op++) begin
            @(posedge clk); #2;
            issue(op % 2, 5'(op), 8'($urandom), 8'($urandom), $sformatf("op%0d", op));
            await_resp(op % 2, 1, $sformatf("op%0d", op));
        end

        // Port 0 response stalled 5 cycles with a new request pending; port 1 served.
        @(posedge clk); #2;
        issue(0, 5'd9, 8'h7F, 8'h00, "stall");
        e0 = q0.pop_front();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                @(posedge clk); #2;
                set_req(0, 1'b1, 5'd13, 8'd1, 8'd2);
                set_req(1, 1'b1, 5'd14, 8'd9, 8'd4);
            end else begin
                @(posedge clk); #2;
                if (i == 1) set_req(1, 1'b0, 5'd14, 8'd9, 8'd4);
                if (i == 3) set_rr(1, 1'b0);
            end
            #1;
            chk($sformatf("stall%0d.rdy0", i), 32'(rdy(0)), 32'd0);
            chk($sformatf("stall%0d.rv0", i), 32'(rvld(0)), 32'd1);
            cmp($sformatf("stall%0d", i), obs(0), e0);
            if (i == 0) begin
                chk("stall.rdy1", 32'(rdy(1)), 32'd1);
                push(1, model(5'd14, 8'd9, 8'd4));
            end
            if (i == 2) begin
                chk("side.rv1", 32'(rvld(1)), 32'd1);
                e = q1.pop_front();
                cmp("side", obs(1), e);
                set_rr(1, 1'b1);
            end
            if (i == 3)
                chk("side.drop", 32'(rvld(1)), 32'd0);
        end
        set_rr(0, 1'b1);
        @(posedge clk); #2;
        set_rr(0, 1'b0);
        #1;
        chk("stall.drop", 32'(rvld(0)), 32'd0);
        chk("stall.rdy0b", 32'(rdy(0)), 32'd1);
        push(0, model(5'd13, 8'd1, 8'd2));
        @(posedge clk); #2;
        set_req(0, 1'b0, 5'd13, 8'd1, 8'd2);
        await_resp(0, 1, "pend");

        // Reset the cycle after a grant: the in-flight op is discarded.
        @(posedge clk); #2;
        issue(0, 5'd13, 8'd3, 8'd4, "lost");
        reset = 1'b1;
        set_req(0, 1'b1, 5'd1, 8'd0, 8'd0);
        set_req(1, 1'b1, 5'd1, 8'd0, 8'd0);
        #1;
        chk("rst2.rdy0", 32'(rdy(0)), 32'd0);
        chk("rst2.rdy1", 32'(rdy(1)), 32'd0);
        chk("rst2.rv0", 32'(rvld(0)), 32'd0);
        set_req(0, 1'b0, 5'd1, 8'd0, 8'd0);
        set_req(1, 1'b0, 5'd1, 8'd0, 8'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        q0.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #3;
            chk($sformatf("post%0d.rv0", i), 32'(rvld(0)), 32'd0);
            chk($sformatf("post%0d.rv1", i), 32'(rvld(1)), 32'd0);
        end
        #1;
        set_req(0, 1'b1, 5'd1, 8'd0, 8'd0);
        set_req(1, 1'b1, 5'd1, 8'd0, 8'd0);
        #1;
        chk("ptr0.rdy0", 32'(rdy(0)), 32'd1);
        chk("ptr0.rdy1", 32'(rdy(1)), 32'd0);
        set_req(0, 1'b0, 5'd1, 8'd0, 8'd0);
        #1;
        chk("elig1.rdy1", 32'(rdy(1)), 32'd1);
        set_req(1, 1'b0, 5'd1, 8'd0, 8'd0);

        chk("q0.empty", 32'(q0.size()), 32'd0);
        chk("q1.empty", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, meaning datapath width passed to the alu instance.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid (N=0,1)  input  1  requester N presents an operation.
REQ-005 SHALL have ports reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 SHALL have ports reqN_op  input  5  function index 0..17, in order: 0, 1, -1, x, y, !x, !y, -x, -y, x+1, y+1, x-1, y-1, x+y, x-y, y-x, x&y, x|y.
REQ-007 SHALL have ports reqN_x, reqN_y  input  W  operands.
REQ-008 SHALL have ports respN_valid  output  1  result held for requester N.
REQ-009 SHALL have ports respN_ready  input  1  requester N consumes the result.
REQ-010 SHALL have ports respN_out  output  W;  respN_zr, respN_ng, respN_err  output  1 each  ALU result, zero flag, negative flag, illegal-op flag.

Function
REQ-011 SHALL share one alu instance between two requesters; a request transfers on reqN_valid && reqN_ready.
REQ-012 SHALL keep per-port busy_N: set on request transfer, cleared on respN_valid && respN_ready; at most one outstanding operation per port.
REQ-013 SHALL compute eligible_N = !busy_N; reqN_ready SHALL never depend on reqN_valid of the same port.
REQ-014 SHALL grant at most one port per cycle; if only one port is valid and eligible, grant it; if both, grant the port selected by the round-robin pointer.
REQ-015 SHALL move the pointer to the other port after every grant; the pointer is unchanged on cycles without a grant.
REQ-016 SHALL decode op to (zx,nx,zy,ny,f,no) via a constant table at acceptance and register controls, operands, port id and err into a single stage-1 register (valid bit s1_v).
REQ-017 SHALL drive the alu from stage 1 in the cycle after acceptance and capture out/zr/ng/err into port s1_id's response register at that cycle's end: respN_valid rises exactly 2 cycles after the transfer cycle.
REQ-018 SHALL hold respN_out/zr/ng/err and respN_valid stable until respN_ready is sampled high; respN_valid SHALL fall the cycle after consumption.
REQ-019 SHALL treat op 18..31 as illegal: apply the constant-0 control word (101010), set err=1; illegal requests SHALL still be accepted and answered.
REQ-020 SHALL sustain one grant per cycle when ports alternate; per-port issue rate is at most one per 3 cycles (grant, compute, consume).
REQ-021 SHALL ignore respN_ready while respN_valid is low; simultaneous consume of port N and grant of port M (M≠N) in one cycle is legal.
REQ-022 SHALL perform all arithmetic modulo 2^W; ng = out[W-1], zr = (out == 0).

Reset
REQ-023 SHALL on reset assertion asynchronously clear busy_0/1, s1_v, respN_valid, respN_out, respN_zr, respN_ng, respN_err, and set the pointer to port 0.
REQ-024 SHALL discard any in-flight operation on reset mid-operation; no response is produced for it after reset release.
REQ-025 SHALL drive reqN_ready low while reset is asserted.

Structure
REQ-026 SHALL place in a shared package: the op-index constants (OP_ZERO..OP_OR), the 18-entry 6-bit control table, OP_COUNT=18 and the illegal-op control word.
REQ-027 SHALL instantiate the existing alu module as its only sub-module, unmodified.

Verification
REQ-028 SHALL cover: req0 op=13 (x+y), x=17, y=6 -> resp0_valid 2 cycles later, out=0x17, zr=0, ng=0, err=0.
REQ-029 SHALL cover: both ports valid same cycle, req0 op=14 (x-y), req1 op=15 (y-x), x=17, y=6 -> port 0 granted first, port 1 next cycle; resp0 out=0x0B ng=0; resp1 out=0xF5 ng=1.
REQ-030 SHALL cover: req0 op=16 (x&y), x=17, y=6 -> out=0x00, zr=1; then op=17 (x|y) -> out=0x17, zr=0.
REQ-031 SHALL cover: req1 op=20 -> accepted, resp1 out=0x00, zr=1, err=1.
REQ-032 SHALL cover: resp0_ready held low 5 cycles with req0_valid high -> req0_ready stays 0, resp0 outputs stable; port 1 continues to be served.
REQ-033 SHALL cover: reset pulse the cycle after a grant -> no respN_valid afterwards, pointer=0, both ports eligible after release.
